// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
// Optional parity frame bit is compiled in with PISO_PARITY_EN.
package piso_pkg;

  localparam int unsigned MAX_W = 64;

`ifdef PISO_PARITY_EN
  localparam int unsigned STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;
`else
  localparam int unsigned STATE_W = 1;
  typedef enum logic [STATE_W-1:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;
`endif

  // Even parity: 1 when the word holds an odd number of ones.
  function automatic logic even_parity(input logic [MAX_W-1:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Producer/consumer handshake bundle for piso_serializer; slave is the serializer side.
interface piso_serializer_if #(
  parameter int unsigned N = 8
);
  logic         clear_i;
  logic [N-1:0] din_i;
  logic         din_valid_i;
  logic         din_ready_o;
  logic         sout_o;
  logic         sout_valid_o;
  logic         sout_ready_i;
  logic         busy_o;
  logic         done_o;

  modport master (
    output clear_i, din_i, din_valid_i, sout_ready_i,
    input  din_ready_o, sout_o, sout_valid_o, busy_o, done_o
  );

  modport slave (
    input  clear_i, din_i, din_valid_i, sout_ready_i,
    output din_ready_o, sout_o, sout_valid_o, busy_o, done_o
  );
endinterface

// File: rtl/piso_bit_counter.sv
// Bit position counter for one frame: sync clear, enable, terminal-count flag at N-1.
module piso_bit_counter #(
  parameter int unsigned N = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] cnt_q;

  // Saturates at N-1; the FSM leaves SHIFT on that accept so it never wraps.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with valid/ready on both sides.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned N         = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic               clk_i,
  input logic               rst_ni,
  piso_serializer_if.slave  bus
);

  state_e       state_q;
  logic [N-1:0] shreg_q;
  logic [N-1:0] shreg_d;
  logic         done_q;
  logic         last_bit;
  logic         cnt_clr;
  logic         cnt_en;
  logic         data_bit;
`ifdef PISO_PARITY_EN
  logic         par_q;
`endif

  // Zero-filled shift toward the end that is currently being emitted.
  always_comb begin
    shreg_d = shreg_q;
    if (MSB_FIRST) shreg_d = {shreg_q[N-2:0], 1'b0};
    else           shreg_d = {1'b0, shreg_q[N-1:1]};
  end

  assign cnt_clr = bus.clear_i || (state_q == IDLE);
  assign cnt_en  = (state_q == SHIFT) && bus.sout_ready_i;

  piso_bit_counter #(.N(N)) u_bit_counter (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .tc_o   (last_bit)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      shreg_q <= '0;
      done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else if (bus.clear_i) begin
      state_q <= IDLE;
      shreg_q <= '0;
      done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.din_valid_i) begin
            shreg_q <= bus.din_i;
            state_q <= SHIFT;
`ifdef PISO_PARITY_EN
            par_q   <= even_parity(MAX_W'(bus.din_i));
`endif
          end
        end
        SHIFT: begin
          if (bus.sout_ready_i) begin
            shreg_q <= shreg_d;
            if (last_bit) begin
`ifdef PISO_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= IDLE;
              done_q  <= 1'b1;
`endif
            end
          end
        end
`ifdef PISO_PARITY_EN
        PARITY: begin
          if (bus.sout_ready_i) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_bit = MSB_FIRST ? shreg_q[N-1] : shreg_q[0];

  // Outputs decode registered state only; sout_ready_i never reaches them.
  assign bus.din_ready_o  = (state_q == IDLE);
  assign bus.sout_valid_o = (state_q != IDLE);
  assign bus.busy_o       = (state_q != IDLE);
  assign bus.done_o       = done_q;
`ifdef PISO_PARITY_EN
  assign bus.sout_o       = (state_q == PARITY) ? par_q : data_bit;
`else
  assign bus.sout_o       = data_bit;
`endif

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: MSB-first and LSB-first instances, queue scoreboard.
// Honours PISO_PARITY_EN when compiled with the same define as the RTL.
module tb_piso_serializer;

  localparam int unsigned N = 8;
`ifdef PISO_PARITY_EN
  localparam int unsigned FRAME = N + 1;
`else
  localparam int unsigned FRAME = N;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic q_m[$];
  logic q_l[$];
  logic exp;

  piso_serializer_if #(.N(N)) bm ();
  piso_serializer_if #(.N(N)) bl ();

  piso_serializer #(.N(N), .MSB_FIRST(1'b1)) u_dut_m (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bm.slave)
  );

  piso_serializer #(.N(N), .MSB_FIRST(1'b0)) u_dut_l (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bl.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference bit order of one frame, data bits then optional parity.
  task automatic push_exp(input logic [N-1:0] w, input bit msb, input bit to_l);
    logic b;
    for (int i = 0; i < int'(N); i++) begin
      b = msb ? w[N-1-i] : w[i];
      if (to_l) q_l.push_back(b);
      else      q_m.push_back(b);
    end
`ifdef PISO_PARITY_EN
    b = ^w;
    if (to_l) q_l.push_back(b);
    else      q_m.push_back(b);
`endif
  endtask

  task automatic load_m(input logic [N-1:0] w);
    bm.din_i       = w;
    bm.din_valid_i = 1'b1;
    push_exp(w, 1'b1, 1'b0);
    tick();
    bm.din_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bm.clear_i = 1'b0; bm.din_i = '0; bm.din_valid_i = 1'b0; bm.sout_ready_i = 1'b0;
    bl.clear_i = 1'b0; bl.din_i = '0; bl.din_valid_i = 1'b0; bl.sout_ready_i = 1'b0;
    repeat (3) tick();
    checks++;
    if ({bm.sout_o, bm.sout_valid_o, bm.busy_o, bm.done_o, bm.din_ready_o} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_m: got %b, expected 00001", {bm.sout_o, bm.sout_valid_o, bm.busy_o, bm.done_o, bm.din_ready_o});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if ({bl.sout_o, bl.sout_valid_o, bl.busy_o, bl.done_o, bl.din_ready_o} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_l: got %b, expected 00001", {bl.sout_o, bl.sout_valid_o, bl.busy_o, bl.done_o, bl.din_ready_o});
    end
  endtask

  task automatic test_msb_first();
    bm.sout_ready_i = 1'b1;
    checks++;
    if (bm.din_ready_o !== 1'b1) begin
      errors++; $display("FAIL msb_ready_idle: got %b, expected 1", bm.din_ready_o);
    end
    load_m(8'hC1);
    for (int i = 0; i < int'(FRAME); i++) begin
      checks++;
      if ({bm.sout_valid_o, bm.busy_o, bm.din_ready_o} !== 3'b110) begin
        errors++; $display("FAIL msb_hs bit %0d: got %b, expected 110", i, {bm.sout_valid_o, bm.busy_o, bm.din_ready_o});
      end
      exp = q_m.pop_front();
      checks++;
      if (bm.sout_o !== exp) begin
        errors++; $display("FAIL msb_bit %0d: got %b, expected %b", i, bm.sout_o, exp);
      end
      tick();
    end
    checks++;
    if ({bm.done_o, bm.din_ready_o, bm.sout_valid_o} !== 3'b110) begin
      errors++; $display("FAIL msb_done: got %b, expected 110", {bm.done_o, bm.din_ready_o, bm.sout_valid_o});
    end
    tick();
    checks++;
    if (bm.done_o !== 1'b0) begin
      errors++; $display("FAIL msb_done_width: got %b, expected 0", bm.done_o);
    end
  endtask

  task automatic test_lsb_first();
    bl.sout_ready_i = 1'b1;
    bl.din_i        = 8'hC1;
    bl.din_valid_i  = 1'b1;
    push_exp(8'hC1, 1'b0, 1'b1);
    tick();
    bl.din_valid_i  = 1'b0;
    for (int i = 0; i < int'(FRAME); i++) begin
      exp = q_l.pop_front();
      checks++;
      if (bl.sout_valid_o !== 1'b1 || bl.sout_o !== exp) begin
        errors++; $display("FAIL lsb_bit %0d: got v=%b d=%b, expected v=1 d=%b", i, bl.sout_valid_o, bl.sout_o, exp);
      end
      tick();
    end
    checks++;
    if (bl.done_o !== 1'b1) begin
      errors++; $display("FAIL lsb_done: got %b, expected 1", bl.done_o);
    end
    bl.sout_ready_i = 1'b0;
  endtask

  task automatic test_backpressure();
    bm.sout_ready_i = 1'b1;
    load_m(8'hC1);
    for (int i = 0; i < int'(FRAME) + 3; i++) begin
      bm.sout_ready_i = !(i >= 2 && i < 5);
      checks++;
      if (bm.sout_valid_o !== 1'b1 || bm.sout_o !== q_m[0]) begin
        errors++; $display("FAIL bp_bit %0d: got v=%b d=%b, expected v=1 d=%b", i, bm.sout_valid_o, bm.sout_o, q_m[0]);
      end
      if (!(i >= 2 && i < 5)) void'(q_m.pop_front());
      else begin
        checks++;
        if (bm.done_o !== 1'b0 || bm.sout_o !== 1'b0) begin
          errors++; $display("FAIL bp_hold %0d: got done=%b d=%b, expected done=0 d=0", i, bm.done_o, bm.sout_o);
        end
      end
      tick();
    end
    bm.sout_ready_i = 1'b1;
    checks++;
    if (bm.done_o !== 1'b1) begin
      errors++; $display("FAIL bp_done: got %b, expected 1", bm.done_o);
    end
  endtask

  task automatic test_busy_ignore();
    bm.sout_ready_i = 1'b1;
    load_m(8'hC1);
    for (int i = 0; i < int'(FRAME); i++) begin
      if (i == 2) begin
        bm.din_i = 8'hFF; bm.din_valid_i = 1'b1;
        checks++;
        if (bm.din_ready_o !== 1'b0) begin
          errors++; $display("FAIL busy_ready: got %b, expected 0", bm.din_ready_o);
        end
      end else begin
        bm.din_valid_i = 1'b0;
      end
      exp = q_m.pop_front();
      checks++;
      if (bm.sout_o !== exp) begin
        errors++; $display("FAIL busy_bit %0d: got %b, expected %b", i, bm.sout_o, exp);
      end
      tick();
    end
    bm.din_valid_i = 1'b0;
    checks++;
    if (bm.done_o !== 1'b1) begin
      errors++; $display("FAIL busy_done: got %b, expected 1", bm.done_o);
    end
  endtask

  task automatic test_clear();
    bm.sout_ready_i = 1'b1;
    load_m(8'hC1);
    for (int i = 0; i < 4; i++) begin
      exp = q_m.pop_front();
      checks++;
      if (bm.sout_o !== exp) begin
        errors++; $display("FAIL clr_bit %0d: got %b, expected %b", i, bm.sout_o, exp);
      end
      tick();
    end
    q_m.delete();
    bm.clear_i = 1'b1;
    tick();
    bm.clear_i = 1'b0;
    checks++;
    if ({bm.sout_o, bm.sout_valid_o, bm.busy_o, bm.done_o, bm.din_ready_o} !== 5'b00001) begin
      errors++; $display("FAIL clr_idle: got %b, expected 00001", {bm.sout_o, bm.sout_valid_o, bm.busy_o, bm.done_o, bm.din_ready_o});
    end
    tick();
    checks++;
    if (bm.done_o !== 1'b0) begin
      errors++; $display("FAIL clr_nodone: got %b, expected 0", bm.done_o);
    end
    // A load in the same cycle as clear must be discarded.
    bm.din_i = 8'hA5; bm.din_valid_i = 1'b1; bm.clear_i = 1'b1;
    tick();
    bm.din_valid_i = 1'b0; bm.clear_i = 1'b0;
    checks++;
    if ({bm.sout_valid_o, bm.busy_o, bm.din_ready_o} !== 3'b001) begin
      errors++; $display("FAIL clr_load: got %b, expected 001", {bm.sout_valid_o, bm.busy_o, bm.din_ready_o});
    end
  endtask

  task automatic test_async_reset();
    bm.sout_ready_i = 1'b1;
    load_m(8'hC1);
    repeat (3) begin
      void'(q_m.pop_front());
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bm.sout_o, bm.sout_valid_o, bm.busy_o, bm.done_o, bm.din_ready_o} !== 5'b00001) begin
      errors++; $display("FAIL arst_out: got %b, expected 00001", {bm.sout_o, bm.sout_valid_o, bm.busy_o, bm.done_o, bm.din_ready_o});
    end
    q_m.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    load_m(8'h5A);
    for (int i = 0; i < int'(FRAME); i++) begin
      exp = q_m.pop_front();
      checks++;
      if (bm.sout_valid_o !== 1'b1 || bm.sout_o !== exp) begin
        errors++; $display("FAIL arst_bit %0d: got v=%b d=%b, expected v=1 d=%b", i, bm.sout_valid_o, bm.sout_o, exp);
      end
      tick();
    end
    checks++;
    if (bm.done_o !== 1'b1) begin
      errors++; $display("FAIL arst_done: got %b, expected 1", bm.done_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] words[4];
    words[0] = 8'hC3;
    words[1] = 8'h5A;
    words[2] = N'($urandom);
    words[3] = N'($urandom);
    bm.sout_ready_i = 1'b1;
    tick();
    for (int w = 0; w < 4; w++) begin
      checks++;
      if (bm.din_ready_o !== 1'b1) begin
        errors++; $display("FAIL b2b_ready word %0d: got %b, expected 1", w, bm.din_ready_o);
      end
      load_m(words[w]);
      for (int i = 0; i < int'(FRAME); i++) begin
        exp = q_m.pop_front();
        checks++;
        if (bm.sout_valid_o !== 1'b1 || bm.sout_o !== exp) begin
          errors++; $display("FAIL b2b_bit w%0d b%0d: got v=%b d=%b, expected v=1 d=%b", w, i, bm.sout_valid_o, bm.sout_o, exp);
        end
        tick();
      end
      checks++;
      if (bm.done_o !== 1'b1) begin
        errors++; $display("FAIL b2b_done word %0d: got %b, expected 1", w, bm.done_o);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_backpressure();
    test_busy_ignore();
    test_clear();
    test_async_reset();
    test_back_to_back();
    checks++;
    if (q_m.size() != 0 || q_l.size() != 0) begin
      errors++; $display("FAIL scoreboard_left: got %0d/%0d entries, expected 0/0", q_m.size(), q_l.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parametrised parallel-in/serial-out serializer with valid/ready handshakes on both sides. It captures an N-bit word and shifts it out one bit per accepted transfer. Shift direction is selectable, the output can stall under backpressure, and the end of each frame is signalled with a pulse. It sits between a parallel producer (register file, FIFO) and a bit-serial link or transmitter front end.

## Interface
- `N`, 8: data word width; legal range 2..64.
- `MSB_FIRST`, 1: 1 = shift out bit N-1 first; 0 = shift out bit 0 first.

- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `clear_i`  in  1  synchronous abort; returns the block to IDLE.
- `din_i`  in  N  parallel word to serialize.
- `din_valid_i`  in  1  producer has a word on `din_i`.
- `din_ready_o`  out  1  block can accept a word.
- `sout_o`  out  1  current serial bit.
- `sout_valid_o`  out  1  `sout_o` holds a valid bit.
- `sout_ready_i`  in  1  consumer accepts `sout_o` this cycle.
- `busy_o`  out  1  a frame is in progress.
- `done_o`  out  1  one-cycle pulse after the last bit of a frame is accepted.

## Operation
- State machine with states IDLE, SHIFT and PARITY. PARITY exists only when `PISO_PARITY_EN` is defined.
- **IDLE**
  - `din_ready_o`=1, `sout_valid_o`=0, `busy_o`=0.
  - On `din_valid_i`&`din_ready_o`: `din_i` → shift register, bit counter → 0, next state SHIFT.
- **SHIFT**
  - `sout_valid_o`=1, `busy_o`=1, `din_ready_o`=0.
  - `sout_o` = shreg[N-1] when `MSB_FIRST`=1, otherwise shreg[0].
  - On `sout_valid_o`&`sout_ready_i`: shift by one (toward the MSB when `MSB_FIRST`=1, toward the LSB otherwise), zero-fill, counter +1.
  - When the accepted bit is bit N-1 of the frame (counter = N-1): go to IDLE, or to PARITY when that feature is compiled in.
- **PARITY**
  - `sout_o` = even parity of the captured word, with `sout_valid_o`=1.
  - On accept: go to IDLE.
- Counter width is `$clog2(N)`. It never exceeds N-1 and does not wrap inside a frame.
- Stall: while `sout_ready_i`=0, `sout_o`, the counter and the state are held, with no limit on stall length.
- `din_valid_i` while not in IDLE is ignored. `din_i` is sampled only at the accept edge.
- Priority order: `rst_ni` > `clear_i` > handshake.
  - `clear_i` in any state → IDLE, shreg=0, counter=0, no `done_o`.
  - `clear_i` in the same cycle as a load accept: the load is discarded.

## Timing
- Reset values:
  - outputs: `sout_o`=0, `sout_valid_o`=0, `busy_o`=0, `done_o`=0, `din_ready_o`=1 (IDLE decode).
  - internal: shreg=0, counter=0, state=IDLE.
- Load to first bit: 1 cycle. The bit is valid on the edge after the accept.
- Frame length with no stalls: N cycles (N+1 with parity).
- Minimum word period: N+1 cycles (N+2 with parity), because IDLE lasts at least one cycle.
- `done_o` is asserted in the first IDLE cycle after the final accept, for exactly one cycle.
- `done_o`, `busy_o` and `sout_valid_o` are registered or decoded from state only. No combinational path from `sout_ready_i` to any output.
- Reset deasserted mid-frame: the block starts in IDLE; the partial frame is lost.

## Configuration
- `PISO_PARITY_EN`
  - Defined: the PARITY state is present. An even-parity bit (XOR of the captured word) is sent as bit N+1. `done_o` follows the parity bit's accept.
  - Undefined: frames are exactly N bits, and the parity logic and state encoding are absent.

## Structure
- Package `piso_pkg` holds:
  - the state enum typedef (IDLE, SHIFT, PARITY);
  - the state-width localparam;
  - the even-parity function.
- Sub-module `piso_bit_counter`: a parametrised up-counter with synchronous clear, enable, and a terminal-count flag at N-1.
- The shift register and FSM stay in the top level.

## Test plan
- Reset, N=8, `MSB_FIRST`=1:
  - load 0xC1 with `sout_ready_i`=1 → `sout_o` = 1,1,0,0,0,0,0,1 on 8 consecutive cycles starting 1 cycle after the accept;
  - `done_o` pulses on cycle 9;
  - `din_ready_o` returns to 1 in that same cycle.
- `MSB_FIRST`=0: load 0xC1 → `sout_o` = 1,0,0,0,0,0,1,1.
- Backpressure: load 0xC1 (`MSB_FIRST`=1) and drop `sout_ready_i` for 3 cycles after 2 bits are accepted → `sout_o` holds 0 with `sout_valid_o`=1, then the remaining bits 0,0,0,0,0,1 follow.
- Busy behaviour:
  - pulse `din_valid_i` with 0xFF during SHIFT → ignored, `din_ready_o`=0, the frame is unchanged;
  - `clear_i` at bit 4 → next cycle IDLE, `sout_valid_o`=0, no `done_o`.
- `PISO_PARITY_EN` defined: load 0xC1 → 8 data bits then parity bit 1. Load 0xC3 → parity bit 0. `done_o` follows the 9th accept.
- Assert `rst_ni`=0 asynchronously mid-frame → all outputs at their reset values immediately. After release, a new load of 0x5A serializes correctly (0,1,0,1,1,0,1,0).
